// File: rtl/write_back_pkg.sv
// Shared encodings for the write-back stage: instruction classes, load/store
// opcode names, memory access sizes and FSM states, plus small decode helpers.
package write_back_pkg;

    // Instruction class carried on the type port
    localparam logic [1:0] T_ALU = 2'd0;
    localparam logic [1:0] T_BR  = 2'd1;
    localparam logic [1:0] T_MEM = 2'd2;
    localparam logic [1:0] T_LUI = 2'd3;

    // MEM opcode names
    localparam logic [5:0] N_LB  = 6'd0;
    localparam logic [5:0] N_LH  = 6'd1;
    localparam logic [5:0] N_LW  = 6'd2;
    localparam logic [5:0] N_LBU = 6'd3;
    localparam logic [5:0] N_LHU = 6'd4;
    localparam logic [5:0] N_SB  = 6'd5;
    localparam logic [5:0] N_SH  = 6'd6;
    localparam logic [5:0] N_SW  = 6'd7;

    // Memory access size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    // Access size for a MEM name; anything unrecognised is a word access
    function automatic logic [1:0] mem_size_of(input logic [5:0] name);
        case (name)
            N_LB, N_LBU, N_SB: mem_size_of = SZ_B;
            N_LH, N_LHU, N_SH: mem_size_of = SZ_H;
            default:           mem_size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] name);
        is_store = (name == N_SB) || (name == N_SH) || (name == N_SW);
    endfunction

endpackage

// File: rtl/write_back_load_ext.sv
// Load extension: turns raw memory read data into the register value
// according to the load name. Unknown names pass the word through.
module load_ext
    import write_back_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      name_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] val_o
);

    // Sign/zero extension from byte 0 or halfword 0
    always_comb begin
        val_o = raw_i;
        case (name_i)
            N_LB:    val_o = {{(XLEN-8){raw_i[7]}}, raw_i[7:0]};
            N_LH:    val_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            N_LBU:   val_o = {{(XLEN-8){1'b0}}, raw_i[7:0]};
            N_LHU:   val_o = {{(XLEN-16){1'b0}}, raw_i[15:0]};
            default: val_o = raw_i;
        endcase
    end

endmodule

// File: rtl/write_back.sv
// Terminal write-back stage. Non-MEM results are written the edge after they
// arrive; MEM ops run a blocking memory transaction (IDLE -> REQ -> COMMIT)
// and return a one-cycle wb_rdy pulse when it completes.
module write_back
    import write_back_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy_i,
    input  logic            rd_rdy_i,
    input  logic            is_vec_i,
    input  logic [1:0]      type_i,
    input  logic [5:0]      name_i,
    input  logic [REGW-1:0] rd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] res_i,
    input  logic [XLEN-1:0] sdata_i,
    output logic            wb_rdy_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [1:0]      mem_size_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_done_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            reg_we_o,
    output logic [REGW-1:0] reg_rd_o,
    output logic [XLEN-1:0] reg_val_o,
    output logic            vreg_we_o,
    output logic            busy_o
);

    state_e            state_q;
    logic [REGW-1:0]   rd_q;
    logic              is_vec_q;
    logic [5:0]        name_q;
    logic              wb_rdy_q, mem_req_q, mem_we_q, reg_we_q, vreg_we_q, busy_q;
    logic [1:0]        mem_size_q;
    logic [XLEN-1:0]   mem_addr_q, mem_wdata_q, reg_val_q;
    logic [REGW-1:0]   reg_rd_q;
    logic [XLEN-1:0]   alu_val_d;
    logic [XLEN-1:0]   ld_val;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .name_i (name_q),
        .raw_i  (mem_rdata_i),
        .val_o  (ld_val)
    );

    // Value written for the single-cycle (non-MEM) classes
    always_comb begin
        alu_val_d = res_i;
        case (type_i)
            T_BR:    alu_val_d = pc_i + XLEN'(4);
            T_LUI:   alu_val_d = imm_i;
            default: alu_val_d = res_i;
        endcase
    end

    // Control FSM with registered outputs; rdy low holds everything,
    // so pulses stretch until rdy returns
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_q        <= '0;
            is_vec_q    <= 1'b0;
            name_q      <= '0;
            wb_rdy_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            vreg_we_q   <= 1'b0;
            reg_rd_q    <= '0;
            reg_val_q   <= '0;
            busy_q      <= 1'b0;
        end else if (rdy_i) begin
            wb_rdy_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            vreg_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_rdy_i) begin
                        if (type_i == T_MEM) begin
                            rd_q        <= rd_i;
                            is_vec_q    <= is_vec_i;
                            name_q      <= name_i;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store(name_i);
                            mem_size_q  <= mem_size_of(name_i);
                            mem_addr_q  <= res_i;
                            mem_wdata_q <= sdata_i;
                            busy_q      <= 1'b1;
                            state_q     <= S_REQ;
                        end else begin
                            reg_rd_q  <= rd_i;
                            reg_val_q <= alu_val_d;
                            reg_we_q  <= !is_vec_i && (rd_i != '0);
                            vreg_we_q <= is_vec_i;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_done_i) begin
                        mem_req_q <= 1'b0;
                        wb_rdy_q  <= 1'b1;
                        state_q   <= S_COMMIT;
                        if (!mem_we_q) begin
                            reg_rd_q  <= rd_q;
                            reg_val_q <= ld_val;
                            reg_we_q  <= !is_vec_q && (rd_q != '0);
                            vreg_we_q <= is_vec_q;
                        end
                    end
                end
                S_COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_rdy_o    = wb_rdy_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_size_o  = mem_size_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign vreg_we_o   = vreg_we_q;
    assign reg_rd_o    = reg_rd_q;
    assign reg_val_o   = reg_val_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/write_back.md
# write_back

Terminal pipeline stage on the consumer side of the forward stage. It accepts one forwarded instruction per cycle and commits its result to the scalar or vector register file. MEM-type instructions are carried through a blocking data-memory transaction. When that transaction completes, the block returns the one-cycle `wb_rdy` pulse that releases the forward stage's bubble stall.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `rdy` in 1: global enable; low freezes all state
- `rd_rdy` in 1: forwarded instruction valid this cycle
- `is_vec` in 1: destination is the vector register file
- `type` in 2: instruction class (`ALU`, `BR`, `MEM`, `LUI`, from const.v)
- `name` in 6: opcode name; for MEM it selects `LB/LH/LW/LBU/LHU/SB/SH/SW`
- `rd` in REGW: destination register
- `pc` in XLEN: instruction PC
- `imm` in XLEN: immediate
- `res` in XLEN: ALU result; for MEM, the effective address
- `sdata` in XLEN: store data (rs2 value)
- `wb_rdy` out 1: one-cycle pulse on MEM completion
- `mem_req` out 1, `mem_we` out 1, `mem_size` out 2 (0=B, 1=H, 2=W), `mem_addr` out XLEN, `mem_wdata` out XLEN: data-memory request
- `mem_done` in 1, `mem_rdata` in XLEN: memory completion and read data
- `reg_we` out 1, `reg_rd` out REGW, `reg_val` out XLEN: scalar register-file write
- `vreg_we` out 1: vector register-file write; shares `reg_rd` and `reg_val`
- `busy` out 1: high while the FSM is not IDLE

## Operation
- FSM states: `IDLE`, `REQ`, `COMMIT`.
- In IDLE, when `rd_rdy` is high and `type != MEM`, the block registers a write in the same edge:
  - `ALU`: value = `res`.
  - `BR`: value = `pc + 4`.
  - `LUI`: value = `imm`.
  - The block stays in IDLE.
- In IDLE, when `rd_rdy` is high and `type == MEM`:
  - Latch `rd`, `is_vec`, `name`, `res` and `sdata`; go to REQ.
  - Drive `mem_req=1`, `mem_addr=res`, `mem_we`, `mem_size` (decoded from `name`) and `mem_wdata=sdata`.
  - Hold all of these stable until `mem_done`.
- In REQ, when `mem_done` is high:
  - Loads: capture `mem_rdata`. `LB`/`LH` sign-extend; `LBU`/`LHU` zero-extend from byte 0 / halfword 0; `LW` passes through.
  - Deassert `mem_req`; go to COMMIT.
- In COMMIT: pulse `wb_rdy` for one cycle; loads also pulse the write; go to IDLE. Stores perform no register write.
- Register-write gating:
  - A scalar write is suppressed when `rd == 0`.
  - Vector writes are never suppressed.
  - `reg_we` and `vreg_we` are mutually exclusive, selected by `is_vec`.
- `rd_rdy` outside IDLE is a protocol violation: it is ignored and must not corrupt latched state (bench assertion). The forward stage guarantees this by stalling.
- Unknown `name` on MEM is treated as `LW`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `wb_rdy`, `mem_req`, `mem_we`, `reg_we`, `vreg_we`, `busy` = 0.
  - `mem_size`, `mem_addr`, `mem_wdata`, `reg_rd`, `reg_val` = 0.
- Reset during REQ abandons the transaction: `mem_req` drops the next cycle and no `wb_rdy` is issued.
- All outputs are registered. Write strobes and `wb_rdy` are single-cycle pulses.
- Non-MEM latency: `rd_rdy` at cycle N gives the write strobe during N+1.
- MEM latency:
  - `rd_rdy` at N gives `mem_req` from N+1.
  - `mem_done` at M gives the load write and `wb_rdy` during M+1, with the FSM back in IDLE at M+2.
  - Minimum round trip (`mem_done` in the first REQ cycle) is 3 cycles.
- `mem_done` coincident with `rst` is dropped.
- `rdy=0` freezes FSM, outputs and latched operands. Pulses stretch while frozen; consumers gate them with `rdy`.

## Structure
- `ALU/BR/MEM/LUI` encodings, load/store `name` codes and `mem_size` encodings live in shared const.v.
- One combinational sub-module, `load_ext`, performs load extension (name, raw data → extended value).

## Test plan
- ALU: `rd_rdy`, `type=ALU`, `rd=5`, `res=0x1234` → next cycle `reg_we=1`, `reg_rd=5`, `reg_val=0x1234`; `wb_rdy` stays 0.
- x0 / vector / BR:
  - `type=ALU`, `rd=0` → no `reg_we`.
  - Same with `is_vec=1` → `vreg_we=1`.
  - `BR` with `pc=0x100` → `reg_val=0x104`.
- `LB`, addr 0x40, `mem_done` after 3 REQ cycles with `mem_rdata=0x000000F0` → `mem_req` held 3 cycles; then `reg_val=0xFFFFFFF0` and a `wb_rdy` pulse; `LBU` gives `0x000000F0`.
- `SW`, `sdata=0xDEADBEEF` → `mem_we=1`, `mem_size=2`; on done, `wb_rdy` pulses with no register write.
- `rdy` dropped mid-REQ for 2 cycles and `rd_rdy` injected while busy → outputs stable, the injected op is ignored, the original load completes correctly.
- `rst` asserted in REQ → `mem_req` drops next cycle, all outputs at reset values, and a new ALU op succeeds immediately afterwards.
